hazard_controller: RTL

Pipeline sequencing controller for the 5-stage RISC-V core. Decides each cycle whether each pipeline register loads, holds or is flushed, based on three conditions:
- load-use hazards between ID and EX;
- taken branches resolved in EX;
- a variable-latency data-memory handshake in MEM.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_controller_if.sv | 37 +++
 rtl/hazard_controller_sat_counter.sv | 19 +
 rtl/hazard_controller.sv | 87 ++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// The control word packs {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex_flush}.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [4:0] X0_IDX = 5'd0;

    localparam logic [6:0] CTL_FREEZE = 7'b00000_00;
    localparam logic [6:0] CTL_NORMAL = 7'b11111_00;
    localparam logic [6:0] CTL_BRANCH = 7'b11111_11;
    localparam logic [6:0] CTL_BUBBLE = 7'b00111_01;

    function automatic logic load_use_hit(input logic       mem_read,
                                          input logic [4:0] rd,
                                          input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return mem_read && (rd != X0_IDX) && ((rd == rs1) || (rd == rs2));
    endfunction

    // Branch beats load-use: the squashed ID instruction no longer needs its operand.
    function automatic logic [6:0] run_ctl(input logic branch, input logic load_use);
        if (branch)        return CTL_BRANCH;
        else if (load_use) return CTL_BUBBLE;
        else               return CTL_NORMAL;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard inputs from ID/EX/MEM and the register enables/flushes driven back to the pipeline.
// Data memory handshake: an access is in flight while dmem_req=1 and completes in the cycle dmem_ready=1.
interface hazard_controller_if #(parameter int CNT_W = 16);
    import hazard_pkg::*;

    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic [4:0]       rd_ex;
    logic             mem_read_ex;
    logic             branch_taken_ex;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    state_t           fsm_state;

    modport master (
        output rs1_id, rs2_id, rd_ex, mem_read_ex, branch_taken_ex, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
        input  halted, stall_cnt, flush_cnt, fsm_state
    );

    modport slave (
        input  rs1_id, rs2_id, rd_ex, mem_read_ex, branch_taken_ex, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
        output halted, stall_cnt, flush_cnt, fsm_state
    );

endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Per-cycle load/hold/flush decisions for the 5-stage pipeline, with a memory-wait
// timeout that halts the core and saturating stall/flush counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.slave  bus
);

    localparam int              WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [6:0]        ctl;
    logic              halted;
    logic              load_use, mem_busy;

    assign load_use = load_use_hit(bus.mem_read_ex, bus.rd_ex, bus.rs1_id, bus.rs2_id);
    assign mem_busy = bus.dmem_req && !bus.dmem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        ctl       = CTL_FREEZE;
        halted    = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state_nxt = MEM_WAIT;
                        wait_nxt  = WAIT_W'(1);
                    end else begin
                        ctl = run_ctl(bus.branch_taken_ex, load_use);
                    end
                end
                MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        ctl       = run_ctl(bus.branch_taken_ex, load_use);
                        state_nxt = RUN;
                        wait_nxt  = '0;
                    end else if (wait_cnt < WAIT_MAX) begin
                        wait_nxt = wait_cnt + 1'b1;
                    end else begin
                        state_nxt = HALT;
                    end
                end
                HALT: halted = 1'b1;
                default: state_nxt = RUN;
            endcase
        end
    end

    assign {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush} = ctl;
    assign bus.halted    = halted;
    assign bus.fsm_state = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!rst && !ctl[6]),
        .q   (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!rst && ctl[1]),
        .q   (bus.flush_cnt)
    );

endmodule
